// File: rtl/uart_rx_controller.sv
// ============================================================================
// uart_rx_controller : UART receive-path configuration sequencer + 4-deep frame FIFO
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_controller #(
  parameter int IDLE_CYCLES   = 160,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [2:0] cfg_baud,
  input  logic       cfg_parity,
  input  logic       cfg_parity_type,
  input  logic       cfg_stop_bits,
  input  logic [3:0] cfg_frame_length,
  output logic       cfg_error,
  input  logic       Rx,
  output logic [2:0] baud,
  output logic       baud_ready,
  output logic       uart_rst,
  output logic       parity,
  output logic       parity_type,
  output logic       stop_bits,
  output logic [3:0] frame_length,
  input  logic [8:0] frame,
  input  logic       frame_valid,
  output logic [8:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       overflow
);

  localparam int MAX_CNT = (IDLE_CYCLES > SETTLE_CYCLES) ? IDLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;

  typedef enum logic [2:0] {
    S_SETTLE = 3'd0,
    S_RUN    = 3'd1,
    S_DRAIN  = 3'd2,
    S_HALT   = 3'd3,
    S_APPLY  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cfg_ready_q, baud_ready_q, uart_rst_q, cfg_error_q, overflow_q;
  logic             accept, reject, cfg_legal, rst_hold_d;

  logic [2:0] baud_q, sh_baud_q;
  logic       parity_q, parity_type_q, stop_bits_q;
  logic       sh_parity_q, sh_parity_type_q, sh_stop_bits_q;
  logic [3:0] frame_length_q, sh_frame_length_q;

  logic       fv_q, fv_prev_q, push_q;
  logic [8:0] frame_q, push_data_q;

  logic [8:0] mem_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q;
  logic       fifo_full, pop, do_push, drop;

  assign cfg_legal = (cfg_frame_length >= 4'd5) && (cfg_frame_length <= 4'd8);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (cfg_valid && cfg_ready_q) begin
          if (cfg_legal) begin
            accept  = 1'b1;
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // Any low bit on the line restarts the whole idle window.
        if (!Rx) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(IDLE_CYCLES - 1)) begin
          state_d = S_HALT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HALT:  state_d = S_APPLY;
      S_APPLY: begin
        state_d = S_SETTLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_SETTLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rst_hold_d = (state_d == S_HALT) || (state_d == S_APPLY) || (state_d == S_SETTLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_SETTLE;
      cnt_q        <= '0;
      cfg_ready_q  <= 1'b0;
      baud_ready_q <= 1'b0;
      uart_rst_q   <= 1'b1;
      cfg_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cfg_ready_q  <= (state_d == S_RUN);
      baud_ready_q <= ~rst_hold_d;
      uart_rst_q   <= rst_hold_d;
      cfg_error_q  <= reject;
    end
  end

  // Shadow copies hold a pending request; live settings only move in APPLY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q            <= 3'b010;
      parity_q          <= 1'b1;
      parity_type_q     <= 1'b0;
      stop_bits_q       <= 1'b1;
      frame_length_q    <= 4'd8;
      sh_baud_q         <= 3'b010;
      sh_parity_q       <= 1'b1;
      sh_parity_type_q  <= 1'b0;
      sh_stop_bits_q    <= 1'b1;
      sh_frame_length_q <= 4'd8;
    end else begin
      if (accept) begin
        sh_baud_q         <= cfg_baud;
        sh_parity_q       <= cfg_parity;
        sh_parity_type_q  <= cfg_parity_type;
        sh_stop_bits_q    <= cfg_stop_bits;
        sh_frame_length_q <= cfg_frame_length;
      end
      if (state_q == S_APPLY) begin
        baud_q         <= sh_baud_q;
        parity_q       <= sh_parity_q;
        parity_type_q  <= sh_parity_type_q;
        stop_bits_q    <= sh_stop_bits_q;
        frame_length_q <= sh_frame_length_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fv_q        <= 1'b0;
      fv_prev_q   <= 1'b0;
      frame_q     <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      fv_q        <= frame_valid;
      fv_prev_q   <= fv_q;
      frame_q     <= frame;
      push_q      <= fv_q & ~fv_prev_q & ~uart_rst_q;
      push_data_q <= frame_q;
    end
  end

  assign fifo_full  = (count_q == 3'd4);
  assign data_valid = (count_q != 3'd0);
  assign data_out   = data_valid ? mem_q[rd_ptr_q] : 9'd0;
  assign pop        = data_valid & data_ready;
  assign do_push    = push_q & (~fifo_full | pop);
  assign drop       = push_q & fifo_full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_q;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({do_push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
      if (drop)        overflow_q <= 1'b1;
      else if (accept) overflow_q <= 1'b0;
    end
  end

  assign cfg_ready    = cfg_ready_q;
  assign baud_ready   = baud_ready_q;
  assign uart_rst     = uart_rst_q;
  assign cfg_error    = cfg_error_q;
  assign overflow     = overflow_q;
  assign baud         = baud_q;
  assign parity       = parity_q;
  assign parity_type  = parity_type_q;
  assign stop_bits    = stop_bits_q;
  assign frame_length = frame_length_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_controller.sv
// ============================================================================
// tb_uart_rx_controller : self-checking bench with frame scoreboard queue
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid, cfg_ready, cfg_parity, cfg_parity_type, cfg_stop_bits, cfg_error;
  logic [2:0] cfg_baud, baud;
  logic [3:0] cfg_frame_length, frame_length;
  logic       Rx, baud_ready, uart_rst, parity, parity_type, stop_bits;
  logic [8:0] frame, data_out;
  logic       frame_valid, data_valid, data_ready, overflow;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q [$];
  logic [8:0] exp_v;

  localparam logic [9:0] SET_DEFAULT = {3'b010, 1'b1, 1'b0, 1'b1, 4'd8};
  localparam logic [9:0] SET_NEW     = {3'b100, 1'b0, 1'b0, 1'b1, 4'd7};

  always #5 clk = ~clk;

  uart_rx_controller #(.IDLE_CYCLES(8), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_baud(cfg_baud),
    .cfg_parity(cfg_parity), .cfg_parity_type(cfg_parity_type),
    .cfg_stop_bits(cfg_stop_bits), .cfg_frame_length(cfg_frame_length),
    .cfg_error(cfg_error), .Rx(Rx), .baud(baud), .baud_ready(baud_ready),
    .uart_rst(uart_rst), .parity(parity), .parity_type(parity_type),
    .stop_bits(stop_bits), .frame_length(frame_length), .frame(frame),
    .frame_valid(frame_valid), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .overflow(overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg(input logic [2:0] b, input logic p, input logic pt,
                           input logic sb, input logic [3:0] len);
    cfg_baud = b; cfg_parity = p; cfg_parity_type = pt;
    cfg_stop_bits = sb; cfg_frame_length = len; cfg_valid = 1'b1;
  endtask

  task automatic send_frame(input logic [8:0] f);
    frame = f; frame_valid = 1'b1;
    tick(); tick();
    frame_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({cfg_ready, baud_ready, uart_rst, cfg_error, overflow, data_valid} !== 6'b001000) begin
      errors++;
      $display("FAIL reset_status got=%b exp=%b",
               {cfg_ready, baud_ready, uart_rst, cfg_error, overflow, data_valid}, 6'b001000);
    end
    checks++;
    if (data_out !== 9'd0) begin
      errors++; $display("FAIL reset_data_out got=%h exp=%h", data_out, 9'd0);
    end
    rst = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      tick();
      if (j < 4) begin
        checks++;
        if (cfg_ready !== 1'b0) begin
          errors++; $display("FAIL reset_settle_ready cycle=%0d got=%b exp=0", j, cfg_ready);
        end
      end
    end
    checks++;
    if ({cfg_ready, baud_ready, uart_rst} !== 3'b110) begin
      errors++; $display("FAIL reset_run got=%b exp=110", {cfg_ready, baud_ready, uart_rst});
    end
    checks++;
    if ({baud, parity, parity_type, stop_bits, frame_length} !== SET_DEFAULT) begin
      errors++; $display("FAIL reset_settings got=%h exp=%h",
                         {baud, parity, parity_type, stop_bits, frame_length}, SET_DEFAULT);
    end
  endtask

  task automatic test_reconfig();
    int n_rst = 0, first_baud = -1, first_rdy = -1;
    Rx = 1'b1;
    drive_cfg(3'b100, 1'b0, 1'b0, 1'b1, 4'd7);
    tick();
    cfg_valid = 1'b0;
    checks++;
    if ({cfg_ready, baud} !== {1'b0, 3'b010}) begin
      errors++; $display("FAIL cfg_drain_entry got=%b exp=%b", {cfg_ready, baud}, {1'b0, 3'b010});
    end
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (uart_rst) n_rst++;
      if (first_baud < 0 && baud == 3'b100) first_baud = j;
      if (first_rdy < 0 && cfg_ready) first_rdy = j;
    end
    checks++;
    if (n_rst != 6) begin
      errors++; $display("FAIL cfg_uart_rst_len got=%0d exp=6", n_rst);
    end
    checks++;
    if (first_baud != 10) begin
      errors++; $display("FAIL cfg_baud_time got=%0d exp=10", first_baud);
    end
    checks++;
    if (first_rdy != 14) begin
      errors++; $display("FAIL cfg_ready_time got=%0d exp=14", first_rdy);
    end
    checks++;
    if ({baud, parity, parity_type, stop_bits, frame_length} !== SET_NEW) begin
      errors++; $display("FAIL cfg_settings got=%h exp=%h",
                         {baud, parity, parity_type, stop_bits, frame_length}, SET_NEW);
    end
  endtask

  task automatic test_rx_glitch();
    int first_rst = -1, first_rdy = -1;
    drive_cfg(3'b100, 1'b0, 1'b0, 1'b1, 4'd7);
    tick();
    cfg_valid = 1'b0;
    for (int j = 1; j <= 25; j++) begin
      tick();
      if (first_rst < 0 && uart_rst) first_rst = j;
      if (first_rdy < 0 && cfg_ready) first_rdy = j;
      if (j == 1) begin
        frame = 9'h1A3; frame_valid = 1'b1; exp_q.push_back(9'h1A3);
      end
      if (j == 3) frame_valid = 1'b0;
      if (j == 4) Rx = 1'b0;
      if (j == 5) Rx = 1'b1;
    end
    checks++;
    if (first_rst != 13) begin
      errors++; $display("FAIL glitch_halt_time got=%0d exp=13", first_rst);
    end
    checks++;
    if (first_rdy != 19) begin
      errors++; $display("FAIL glitch_ready_time got=%0d exp=19", first_rdy);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if ({data_valid, data_out} !== {1'b1, exp_v}) begin
      errors++; $display("FAIL glitch_frame got=%b/%h exp=1/%h", data_valid, data_out, exp_v);
    end
    data_ready = 1'b1; tick(); data_ready = 1'b0;
    checks++;
    if (data_valid !== 1'b0) begin
      errors++; $display("FAIL glitch_empty got=%b exp=0", data_valid);
    end
  endtask

  task automatic test_cfg_error();
    logic [3:0] bad [2];
    bad[0] = 4'd9; bad[1] = 4'd4;
    for (int i = 0; i < 2; i++) begin
      int np = 0;
      drive_cfg(3'b111, 1'b1, 1'b1, 1'b0, bad[i]);
      tick();
      cfg_valid = 1'b0;
      if (cfg_error) np++;
      for (int j = 0; j < 3; j++) begin
        tick();
        if (cfg_error) np++;
      end
      checks++;
      if (np != 1) begin
        errors++; $display("FAIL cfg_error_pulses len=%0d got=%0d exp=1", bad[i], np);
      end
      checks++;
      if ({cfg_ready, baud, parity, parity_type, stop_bits, frame_length} !== {1'b1, SET_NEW}) begin
        errors++; $display("FAIL cfg_error_unchanged got=%h exp=%h",
                           {cfg_ready, baud, parity, parity_type, stop_bits, frame_length},
                           {1'b1, SET_NEW});
      end
    end
  endtask

  task automatic test_full_push_pop();
    logic [8:0] fills [4];
    fills[0] = 9'h011; fills[1] = 9'h022; fills[2] = 9'h033; fills[3] = 9'h044;
    for (int i = 0; i < 4; i++) begin
      send_frame(fills[i]);
      exp_q.push_back(fills[i]);
    end
    frame = 9'h055; frame_valid = 1'b1;
    tick(); tick();
    exp_v = exp_q.pop_front();
    checks++;
    if ({data_valid, data_out} !== {1'b1, exp_v}) begin
      errors++; $display("FAIL fullpp_head got=%b/%h exp=1/%h", data_valid, data_out, exp_v);
    end
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0; frame_valid = 1'b0;
    exp_q.push_back(9'h055);
    tick();
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL fullpp_overflow got=%b exp=0", overflow);
    end
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if ({data_valid, data_out} !== {1'b1, exp_v}) begin
        errors++; $display("FAIL fullpp_pop got=%b/%h exp=1/%h", data_valid, data_out, exp_v);
      end
      data_ready = 1'b1; tick(); data_ready = 1'b0;
    end
    checks++;
    if (data_valid !== 1'b0) begin
      errors++; $display("FAIL fullpp_empty got=%b exp=0", data_valid);
    end
  endtask

  task automatic test_overflow();
    logic [8:0] rest [4];
    rest[0] = 9'h13C; rest[1] = 9'h1FF; rest[2] = 9'h000; rest[3] = 9'h0F0;
    frame = 9'h0A5; frame_valid = 1'b1; exp_q.push_back(9'h0A5);
    tick();
    checks++;
    if (data_valid !== 1'b0) begin
      errors++; $display("FAIL latency_k got=%b exp=0", data_valid);
    end
    tick();
    checks++;
    if (data_valid !== 1'b0) begin
      errors++; $display("FAIL latency_k1 got=%b exp=0", data_valid);
    end
    tick();
    checks++;
    if ({data_valid, data_out} !== {1'b1, 9'h0A5}) begin
      errors++; $display("FAIL latency_k2 got=%b/%h exp=1/0a5", data_valid, data_out);
    end
    frame_valid = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin
      send_frame(rest[i]);
      if (i < 3) exp_q.push_back(rest[i]);
    end
    tick();
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set got=%b exp=1", overflow);
    end
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if ({data_valid, data_out} !== {1'b1, exp_v}) begin
        errors++; $display("FAIL ovf_pop got=%b/%h exp=1/%h", data_valid, data_out, exp_v);
      end
      data_ready = 1'b1; tick(); data_ready = 1'b0;
    end
    checks++;
    if ({data_valid, overflow} !== 2'b01) begin
      errors++; $display("FAIL ovf_drained got=%b exp=01", {data_valid, overflow});
    end
  endtask

  task automatic test_async_reset();
    drive_cfg(3'b001, 1'b1, 1'b1, 1'b0, 4'd5);
    tick();
    cfg_valid = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cfg_ready, baud_ready, uart_rst, overflow, baud, parity, parity_type, stop_bits,
         frame_length} !== {4'b0010, SET_DEFAULT}) begin
      errors++; $display("FAIL async_reset got=%h exp=%h",
                         {cfg_ready, baud_ready, uart_rst, overflow, baud, parity, parity_type,
                          stop_bits, frame_length}, {4'b0010, SET_DEFAULT});
    end
    tick();
    rst = 1'b0;
    repeat (25) tick();
    checks++;
    if ({cfg_ready, baud, parity, parity_type, stop_bits, frame_length} !== {1'b1, SET_DEFAULT}) begin
      errors++; $display("FAIL async_discard got=%h exp=%h",
                         {cfg_ready, baud, parity, parity_type, stop_bits, frame_length},
                         {1'b1, SET_DEFAULT});
    end
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_baud = 3'b000; cfg_parity = 1'b0;
    cfg_parity_type = 1'b0; cfg_stop_bits = 1'b0; cfg_frame_length = 4'd8;
    Rx = 1'b1; frame = 9'd0; frame_valid = 1'b0; data_ready = 1'b0;
    test_reset();
    test_reconfig();
    test_rx_glitch();
    test_cfg_error();
    test_full_push_pop();
    test_overflow();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_controller.md
# uart_rx_controller

Run-time configuration sequencer and receive buffer for the UART receive path. Owns the `baud`/`baud_ready` inputs of `clock_handler` and the parity/stop/length configuration of `UART_processor`. Reconfiguration happens only once the serial line has been idle long enough, and the receiver is held in reset while settings change. Completed frames are captured into a 4-entry FIFO for the downstream VGA text logic.

## Interface
- IDLE_CYCLES, 160: consecutive `clk` cycles with `Rx`=1 required before a reconfiguration is applied.
- SETTLE_CYCLES, 16: `clk` cycles the receiver stays in reset after new settings are applied.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  controller can accept a configuration.
- cfg_baud  in  3  requested baud code.
- cfg_parity  in  1  requested parity enable.
- cfg_parity_type  in  1  requested parity type.
- cfg_stop_bits  in  1  requested stop-bit setting.
- cfg_frame_length  in  4  requested data bits; legal range 5..8.
- cfg_error  out  1  one-cycle pulse when an illegal configuration is rejected.
- Rx  in  1  serial line, monitored for idle; synchronous to `clk`.
- baud  out  3  baud code to `clock_handler`.
- baud_ready  out  1  baud code valid, to `clock_handler`.
- uart_rst  out  1  reset to `UART_processor`, active-high.
- parity, parity_type, stop_bits  out  1 each  settings to `UART_processor`.
- frame_length  out  4  data-bit count to `UART_processor`.
- frame  in  9  received frame from `UART_processor`.
- frame_valid  in  1  frame-complete level; may stay high for several cycles.
- data_out  out  9  FIFO head.
- data_valid  out  1  FIFO not empty.
- data_ready  in  1  downstream pop.
- overflow  out  1  sticky: a frame was dropped because the FIFO was full.

## Operation
- FSM states and behaviour:
  - SETTLE: `uart_rst`=1, `baud_ready`=0. The counter runs 0..SETTLE_CYCLES-1, then the FSM goes to RUN.
  - RUN: `uart_rst`=0, `baud_ready`=1, `cfg_ready`=1.
  - DRAIN: waits for line idle.
  - HALT: 1 cycle; `uart_rst`=1, `baud_ready`=0.
  - APPLY: 1 cycle; settings outputs take the shadow values. Then SETTLE.
- Reset values:
  - Settings: `baud`=3'b010, `parity`=1, `parity_type`=0, `stop_bits`=1, `frame_length`=8.
  - State: FSM enters SETTLE with counter 0; `uart_rst`=1, `baud_ready`=0, `cfg_ready`=0.
  - Status and FIFO: `cfg_error`=0, `overflow`=0, FIFO empty, `data_valid`=0, `data_out`=0.
- Configuration handshake:
  - A request is accepted on `cfg_valid & cfg_ready`, which is possible in RUN only.
  - If `cfg_frame_length` is outside 5..8: pulse `cfg_error` for 1 cycle, stay in RUN, change nothing.
  - Otherwise: latch all `cfg_*` into shadow registers, clear `overflow`, go to DRAIN.
- DRAIN:
  - The counter is cleared on entry.
  - `Rx`=0 clears the counter. `Rx`=1 increments it.
  - When `Rx`=1 and the counter equals IDLE_CYCLES-1, go to HALT.
  - Settings outputs stay at their old values until APPLY.
- Frame capture:
  - `frame_valid` is registered and rising-edge detected. Each rising edge pushes `frame` once.
  - Edges are ignored while `uart_rst`=1, i.e. in HALT, APPLY and SETTLE.
- FIFO:
  - 4 entries, first-in first-out; pop on `data_valid & data_ready`.
  - Push while full without a same-cycle pop: the frame is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: both succeed; `overflow` is unchanged.
  - Push and pop in the same cycle while holding one entry: the new frame becomes the head next cycle.
  - FIFO contents are preserved across reconfiguration.
- Asynchronous reset mid-sequence: everything returns to the reset values and the pending shadow configuration is discarded.

## Timing
- Accept at edge N:
  - DRAIN occupies cycles N+1 .. N+IDLE_CYCLES when `Rx` is idle throughout.
  - HALT is cycle N+IDLE_CYCLES+1; APPLY is N+IDLE_CYCLES+2.
  - New settings are visible from cycle N+IDLE_CYCLES+3.
  - `cfg_ready`=1, `baud_ready`=1 and `uart_rst`=0 from cycle N+IDLE_CYCLES+3+SETTLE_CYCLES.
- After reset release: RUN after SETTLE_CYCLES cycles.
- Frame latency: a `frame_valid` rising edge sampled at edge k into an empty FIFO gives `data_valid`=1 with `data_out`=`frame` after edge k+2 (one cycle for the edge register, one for the FIFO write).
- All outputs are registered except `data_valid` and `data_out`, which decode directly from the FIFO pointers and storage.
- A `Rx` low pulse in the last DRAIN cycle restarts the full IDLE_CYCLES wait.

## Test plan
- Bench parameters IDLE_CYCLES=8, SETTLE_CYCLES=4:
  - Reset release: `cfg_ready`=0 for 4 cycles, then `cfg_ready`=1, `baud_ready`=1, `uart_rst`=0.
  - Settings read 3'b010 / 1 / 0 / 1 / 8.
- Config {baud=3'b100, parity=0, frame_length=7} with `Rx`=1: `uart_rst` high exactly 6 cycles (HALT, APPLY, SETTLE); `baud`=3'b100 appears at accept+11; `cfg_ready` returns at accept+15.
- Same config with `Rx`=0 at DRAIN cycle 5:
  - HALT is delayed until 8 further idle cycles have elapsed.
  - A `frame_valid` rising edge during DRAIN is still pushed to the FIFO.
- `cfg_frame_length`=9, then 4: `cfg_error` pulses once for each; settings unchanged; `cfg_ready` stays 1.
- Five frames 0x0A5, 0x13C, 0x1FF, 0x000, 0x0F0 with `data_ready`=0:
  - First four are stored, fifth is dropped, `overflow`=1.
  - Popping yields 0x0A5, 0x13C, 0x1FF, 0x000.
- Full FIFO, push 0x055 with simultaneous pop: no overflow; 0x055 is read out last.
